// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction side and downstream result side.
// The master drives instructions and out_ready. The slave is the generator.
interface imm_gen_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [2:0]            out_fmt;
    logic                  out_has_imm;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_has_imm, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_has_imm, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode into an output register,
// backed by a one-entry skid buffer so in_ready is purely registered.
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0]           ins;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic signed [11:0]    imm_i;
    logic signed [11:0]    imm_s;
    logic signed [12:0]    imm_b;
    logic signed [20:0]    imm_j;
    logic signed [31:0]    imm_u;
    logic [DATA_WIDTH-1:0] dec_imm;
    fmt_e                  dec_fmt;

    // Signed intermediates let the size cast perform sign extension to DATA_WIDTH.
    always_comb begin
        ins     = bus.in_instr;
        opcode  = ins[6:0];
        funct3  = ins[14:12];
        imm_i   = ins[31:20];
        imm_s   = {ins[31:25], ins[11:7]};
        imm_b   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_u   = {ins[31:12], 12'b0};
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = DATA_WIDTH'(imm_i);
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt = FMT_SHAMT;
                    if (DATA_WIDTH == 64) dec_imm = DATA_WIDTH'(ins[25:20]);
                    else                  dec_imm = DATA_WIDTH'(ins[24:20]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = DATA_WIDTH'(imm_i);
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = DATA_WIDTH'(imm_s);
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = DATA_WIDTH'(imm_b);
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = DATA_WIDTH'(imm_j);
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = DATA_WIDTH'(imm_u);
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    dec_fmt = FMT_ZIMM;
                    dec_imm = DATA_WIDTH'(ins[19:15]);
                end
            end
            default: begin
                dec_fmt = FMT_NONE;
                dec_imm = '0;
            end
        endcase
    end

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_imm_q;
    fmt_e                  out_fmt_q;
    logic                  out_has_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_imm;
    fmt_e                  skid_fmt;
    logic                  skid_has;
    logic [TAG_WIDTH-1:0]  skid_tag;

    logic accept;
    logic out_free;

    assign accept   = bus.in_valid && !skid_valid;
    assign out_free = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_fmt_q   <= FMT_NONE;
            out_has_q   <= 1'b0;
            out_tag_q   <= '0;
            skid_valid  <= 1'b0;
            skid_imm    <= '0;
            skid_fmt    <= FMT_NONE;
            skid_has    <= 1'b0;
            skid_tag    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (out_free) begin
            // Skid entry is older than anything upstream, so it always drains first.
            if (skid_valid) begin
                out_valid_q <= 1'b1;
                out_imm_q   <= skid_imm;
                out_fmt_q   <= skid_fmt;
                out_has_q   <= skid_has;
                out_tag_q   <= skid_tag;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_imm_q   <= dec_imm;
                out_fmt_q   <= dec_fmt;
                out_has_q   <= (dec_fmt != FMT_NONE);
                out_tag_q   <= bus.in_tag;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_has   <= (dec_fmt != FMT_NONE);
            skid_tag   <= bus.in_tag;
        end
    end

    assign bus.in_ready    = !skid_valid;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_fmt     = out_fmt_q;
    assign bus.out_has_imm = out_has_q;
    assign bus.out_tag     = out_tag_q;
endmodule
